rpn_stack_calc: RTL and testbench

Parametrised stack-based (RPN) calculator core, the next generation of the board-level calculator state machine. Instead of a fixed A/B/opcode entry sequence, operands are pushed onto a C_DEPTH-entry operand stack, and operations consume the top two entries and push the result. Width is parametrised. Overflow and underflow are detected and reported. The block sits between the push-button debouncers, which supply single-cycle pulses, and the 7-segment/LED display driver.

---
 rtl/rpn_stack_calc.sv | 162 ++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calc.sv
// RPN calculator core: operands are pushed onto a small register stack, and each op
// replaces the top two entries with their result. Status flags and reject status are registered.
module rpn_stack_calc #(
  parameter int C_WIDTH = 16,
  parameter int C_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         op,
  input  logic                         drop,
  input  logic [C_WIDTH-1:0]           value,
  output logic [C_WIDTH-1:0]           display,
  output logic [3:0]                   flags,
  output logic [$clog2(C_DEPTH+1)-1:0] depth,
  output logic                         err
);

  localparam int CNT_W = $clog2(C_DEPTH + 1);
  localparam int IDX_W = $clog2(C_DEPTH);

  typedef enum logic [1:0] {
    OPC_ADD = 2'b00,
    OPC_SUB = 2'b01,
    OPC_OR  = 2'b10,
    OPC_AND = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_PUSH,
    CMD_OP,
    CMD_DROP
  } cmd_e;

  logic [C_WIDTH-1:0] stack_q [C_DEPTH];
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         flags_q;
  logic               err_q;

  cmd_e               cmd;
  opcode_e            opcode;
  logic               can_push;
  logic               can_op;
  logic               can_drop;
  logic [IDX_W-1:0]   tos_idx;
  logic [IDX_W-1:0]   nos_idx;
  logic [IDX_W-1:0]   push_idx;

  logic [C_WIDTH-1:0] operand_a;
  logic [C_WIDTH-1:0] operand_b;
  logic [C_WIDTH-1:0] addend;
  logic [C_WIDTH:0]   sum;
  logic [C_WIDTH-1:0] result;
  logic               carry;
  logic               overflow;
  logic [3:0]         flags_next;

  // Lower-priority pulses arriving in the same cycle are simply dropped.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd = CMD_NONE;
    if (push) begin
      cmd = CMD_PUSH;
    end else if (op) begin
      cmd = CMD_OP;
    end else if (drop) begin
      cmd = CMD_DROP;
    end
  end

  assign can_push = (cnt_q < CNT_W'(C_DEPTH));
  assign can_op   = (cnt_q >= CNT_W'(2));
  assign can_drop = (cnt_q != '0);

  // Indices only matter when the matching guard above holds; they wrap harmlessly otherwise.
  assign tos_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign nos_idx  = IDX_W'(cnt_q - CNT_W'(2));
  assign push_idx = IDX_W'(cnt_q);

  assign opcode    = opcode_e'(value[1:0]);
  assign operand_a = stack_q[tos_idx];
  assign operand_b = stack_q[nos_idx];

  // Subtraction reuses the adder as B + ~A + 1, so carry out means "no borrow".
  always_comb begin
    addend     = operand_a;
    sum        = '0;
    result     = '0;
    carry      = 1'b0;
    overflow   = 1'b0;
    flags_next = '0;
    unique case (opcode)
      OPC_ADD, OPC_SUB: begin
        if (opcode == OPC_SUB) begin
          addend = ~operand_a;
        end
        sum = {1'b0, operand_b} + {1'b0, addend}
            + {{C_WIDTH{1'b0}}, (opcode == OPC_SUB)};
        result   = sum[C_WIDTH-1:0];
        carry    = sum[C_WIDTH];
        overflow = (operand_b[C_WIDTH-1] == addend[C_WIDTH-1])
                && (result[C_WIDTH-1] != operand_b[C_WIDTH-1]);
      end
      OPC_OR:  result = operand_b | operand_a;
      OPC_AND: result = operand_b & operand_a;
      default: result = '0;
    endcase
    flags_next = {result[C_WIDTH-1], (result == '0), carry, overflow};
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      // NOTE: the stack array is reset as well, so its contents are defined from the first cycle.
      for (int i = 0; i < C_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      unique case (cmd)
        CMD_PUSH: begin
          if (can_push) begin
            stack_q[push_idx] <= value;
            cnt_q             <= cnt_q + CNT_W'(1);
            err_q             <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        CMD_OP: begin
          if (can_op) begin
            stack_q[nos_idx] <= result;
            cnt_q            <= cnt_q - CNT_W'(1);
            flags_q          <= flags_next;
            err_q            <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        CMD_DROP: begin
          if (can_drop) begin
            cnt_q <= cnt_q - CNT_W'(1);
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // With an empty stack the display echoes the switches so the operator sees what will be pushed.
  assign display = (cnt_q == '0) ? value : stack_q[tos_idx];
  assign depth   = cnt_q;
  assign flags   = flags_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: a queue-based reference model checked every cycle, plus
// hand-computed literal expectations, on a 16x4 and an 8x2 instance.
module tb_rpn_stack_calc;

  logic        clk = 1'b0;
  logic        rst;

  logic        push16, op16, drop16;
  logic [15:0] value16;
  logic [15:0] display16;
  logic [3:0]  flags16;
  logic [2:0]  depth16;
  logic        err16;

  logic        push8, op8, drop8;
  logic [7:0]  value8;
  logic [7:0]  display8;
  logic [3:0]  flags8;
  logic [1:0]  depth8;
  logic        err8;

  int n_checks = 0;
  int n_fail   = 0;

  longint      m16[$];
  logic [3:0]  mf16;
  logic        me16;
  longint      m8[$];
  logic [3:0]  mf8;
  logic        me8;
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  rpn_stack_calc #(.C_WIDTH(16), .C_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst), .push(push16), .op(op16), .drop(drop16), .value(value16),
    .display(display16), .flags(flags16), .depth(depth16), .err(err16)
  );

  rpn_stack_calc #(.C_WIDTH(8), .C_DEPTH(2)) dut8 (
    .clk(clk), .rst(rst), .push(push8), .op(op8), .drop(drop8), .value(value8),
    .display(display8), .flags(flags8), .depth(depth8), .err(err8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic on plain integers: unsigned range for C, signed range for V.
  function automatic void alu_model(input int w, input logic [1:0] opc, input longint b,
                                    input longint a, output longint r, output logic [3:0] f);
    longint m, half, sb, sa, full, sfull;
    logic   c, v;
    m     = longint'(1) << w;
    half  = m / 2;
    sb    = (b >= half) ? b - m : b;
    sa    = (a >= half) ? a - m : a;
    c     = 1'b0;
    v     = 1'b0;
    full  = 0;
    sfull = 0;
    case (opc)
      2'd0: begin
        full  = b + a;
        c     = (full >= m);
        sfull = sb + sa;
        v     = (sfull >= half) || (sfull < -half);
      end
      2'd1: begin
        full  = b - a;
        c     = (b >= a);
        sfull = sb - sa;
        v     = (sfull >= half) || (sfull < -half);
      end
      2'd2: full = b | a;
      default: full = b & a;
    endcase
    r = ((full % m) + m) % m;
    f = {(r >= half), (r == 0), c, v};
  endfunction

  initial begin : model
    longint a, b, r;
    logic [3:0] f;
    forever begin
      @(posedge clk);
      if (rst) begin
        m16.delete(); mf16 = '0; me16 = 1'b0;
        m8.delete();  mf8  = '0; me8  = 1'b0;
        model_valid = 1'b1;
      end else begin
        if (push16) begin
          if (m16.size() < 4) begin m16.push_back(longint'(value16)); me16 = 1'b0; end
          else me16 = 1'b1;
        end else if (op16) begin
          if (m16.size() >= 2) begin
            a = m16.pop_back(); b = m16.pop_back();
            alu_model(16, value16[1:0], b, a, r, f);
            m16.push_back(r); mf16 = f; me16 = 1'b0;
          end else me16 = 1'b1;
        end else if (drop16) begin
          if (m16.size() >= 1) begin void'(m16.pop_back()); me16 = 1'b0; end
          else me16 = 1'b1;
        end
        if (push8) begin
          if (m8.size() < 2) begin m8.push_back(longint'(value8)); me8 = 1'b0; end
          else me8 = 1'b1;
        end else if (op8) begin
          if (m8.size() >= 2) begin
            a = m8.pop_back(); b = m8.pop_back();
            alu_model(8, value8[1:0], b, a, r, f);
            m8.push_back(r); mf8 = f; me8 = 1'b0;
          end else me8 = 1'b1;
        end else if (drop8) begin
          if (m8.size() >= 1) begin void'(m8.pop_back()); me8 = 1'b0; end
          else me8 = 1'b1;
        end
      end
    end
  end

  initial begin : compare
    longint exp_disp;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        exp_disp = (m16.size() == 0) ? longint'(value16) : m16[m16.size()-1];
        check("depth16",   32'(depth16),   32'(m16.size()));
        check("display16", 32'(display16), 32'(exp_disp));
        check("flags16",   32'(flags16),   32'(mf16));
        check("err16",     32'(err16),     32'(me16));
        exp_disp = (m8.size() == 0) ? longint'(value8) : m8[m8.size()-1];
        check("depth8",    32'(depth8),    32'(m8.size()));
        check("display8",  32'(display8),  32'(exp_disp));
        check("flags8",    32'(flags8),    32'(mf8));
        check("err8",      32'(err8),      32'(me8));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cmd16(input logic p, input logic o, input logic d, input logic [15:0] v);
    @(posedge clk); #1;
    push16 = p; op16 = o; drop16 = d; value16 = v;
    @(posedge clk); #1;
    push16 = 1'b0; op16 = 1'b0; drop16 = 1'b0;
  endtask

  task automatic do_push16(input logic [15:0] v);
    cmd16(1'b1, 1'b0, 1'b0, v);
  endtask

  task automatic do_op16(input logic [1:0] opc);
    cmd16(1'b0, 1'b1, 1'b0, {14'd0, opc});
  endtask

  task automatic do_drop16();
    cmd16(1'b0, 1'b0, 1'b1, value16);
  endtask

  task automatic cmd8(input logic p, input logic o, input logic d, input logic [7:0] v);
    @(posedge clk); #1;
    push8 = p; op8 = o; drop8 = d; value8 = v;
    @(posedge clk); #1;
    push8 = 1'b0; op8 = 1'b0; drop8 = 1'b0;
  endtask

  initial begin : stimulus
    rst = 1'b1;
    push16 = 1'b0; op16 = 1'b0; drop16 = 1'b0; value16 = '0;
    push8  = 1'b0; op8  = 1'b0; drop8  = 1'b0; value8  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    value16 = 16'h1234;
    value8  = 8'h5A;
    #1;
    check("reset depth16",   32'(depth16),   32'd0);
    check("reset display16", 32'(display16), 32'h1234);
    check("reset flags16",   32'(flags16),   32'd0);
    check("reset err16",     32'(err16),     32'd0);
    check("reset display8",  32'(display8),  32'h5A);

    // Push then add
    do_push16(16'h0003); do_push16(16'h0005); do_op16(2'b00);
    check("add depth",   32'(depth16),   32'd1);
    check("add display", 32'(display16), 32'h0008);
    check("add flags",   32'(flags16),   32'b0000);
    check("add err",     32'(err16),     32'd0);
    do_drop16();

    // Subtract with borrow
    do_push16(16'h0002); do_push16(16'h0005); do_op16(2'b01);
    check("sub display", 32'(display16), 32'hFFFD);
    check("sub flags",   32'(flags16),   32'b1000);
    do_drop16();

    // Signed overflow, AND, OR, zero
    do_push16(16'h7FFF); do_push16(16'h0001); do_op16(2'b00);
    check("ovf display", 32'(display16), 32'h8000);
    check("ovf flags",   32'(flags16),   32'b1001);
    do_push16(16'h8000); do_op16(2'b11);
    check("and display", 32'(display16), 32'h8000);
    check("and flags",   32'(flags16),   32'b1000);
    do_push16(16'h0000); do_op16(2'b10);
    check("or display",  32'(display16), 32'h8000);
    check("or flags",    32'(flags16),   32'b1000);
    do_drop16();
    do_push16(16'h00F0); do_push16(16'h000F); do_op16(2'b11);
    check("zero display", 32'(display16), 32'h0000);
    check("zero flags",   32'(flags16),   32'b0100);
    do_drop16();
    do_push16(16'hFFFF); do_push16(16'h0001); do_op16(2'b00);
    check("carry display", 32'(display16), 32'h0000);
    check("carry flags",   32'(flags16),   32'b0110);
    do_drop16();

    // Full and underflow
    do_push16(16'h0001); do_push16(16'h0002); do_push16(16'h0003); do_push16(16'h0004);
    check("full depth", 32'(depth16), 32'd4);
    do_push16(16'h0005);
    check("overfill err",   32'(err16),     32'd1);
    check("overfill depth", 32'(depth16),   32'd4);
    check("overfill tos",   32'(display16), 32'h0004);
    repeat (4) do_drop16();
    check("empty depth", 32'(depth16), 32'd0);
    check("empty err",   32'(err16),   32'd0);
    value16 = 16'h0BEE;
    #1 check("empty display", 32'(display16), 32'h0BEE);
    do_drop16();
    check("underflow err", 32'(err16), 32'd1);
    do_push16(16'h0009);
    check("push clears err", 32'(err16), 32'd0);
    do_op16(2'b00);
    check("short op err",   32'(err16),   32'd1);
    check("short op flags", 32'(flags16), 32'b0110);
    check("short op depth", 32'(depth16), 32'd1);

    // Simultaneous commands, held pulse, reset wins
    do_push16(16'h0007);
    cmd16(1'b1, 1'b1, 1'b0, 16'h0011);
    check("push+op depth",   32'(depth16),   32'd3);
    check("push+op display", 32'(display16), 32'h0011);
    cmd16(1'b0, 1'b1, 1'b1, 16'h0000);
    check("op+drop depth",   32'(depth16),   32'd2);
    check("op+drop display", 32'(display16), 32'h0018);
    @(posedge clk); #1;
    push16 = 1'b1; value16 = 16'h00AA;
    repeat (2) @(posedge clk);
    #1 push16 = 1'b0;
    check("held push depth", 32'(depth16), 32'd4);
    do_push16(16'h00BB);
    check("pre-reset err", 32'(err16), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; push16 = 1'b1; value16 = 16'h0055;
    @(posedge clk); #1;
    rst = 1'b0; push16 = 1'b0;
    check("rst+push depth",   32'(depth16),   32'd0);
    check("rst+push err",     32'(err16),     32'd0);
    check("rst+push flags",   32'(flags16),   32'd0);
    check("rst+push display", 32'(display16), 32'h0055);

    // 8-bit, 2-entry instance
    cmd8(1'b1, 1'b0, 1'b0, 8'hFF);
    cmd8(1'b1, 1'b0, 1'b0, 8'h01);
    cmd8(1'b0, 1'b1, 1'b0, 8'h00);
    check("w8 add display", 32'(display8), 32'h00);
    check("w8 add flags",   32'(flags8),   32'b0110);
    check("w8 add depth",   32'(depth8),   32'd1);
    cmd8(1'b1, 1'b0, 1'b0, 8'h22);
    check("w8 refill depth", 32'(depth8), 32'd2);
    cmd8(1'b1, 1'b0, 1'b0, 8'h33);
    check("w8 full err",     32'(err8),     32'd1);
    check("w8 full depth",   32'(depth8),   32'd2);
    check("w8 full display", 32'(display8), 32'h22);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
